// File: rtl/select_driver_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : select_driver_if
// Brief  : Request/response handshake between an upstream requester and the
//          select_driver. The requester offers 1-bit steering decisions on a
//          valid/ready stream; the driver answers with a one-cycle done pulse
//          and the branch that completed.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
interface select_driver_if;
  logic req_valid;
  logic req_sel;
  logic req_ready;
  logic done;
  logic done_branch;

  modport master (
    output req_valid,
    output req_sel,
    input  req_ready,
    input  done,
    input  done_branch
  );

  modport slave (
    input  req_valid,
    input  req_sel,
    output req_ready,
    output done,
    output done_branch
  );
endinterface
`default_nettype wire

// File: rtl/select_driver.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : select_driver
// Brief  : Clocked front-end for a 2-phase select element. Each accepted
//          request drives the bundled steering value, issues one transition
//          on the select's event input, watches the synchronised true/false
//          outputs and reports completion before taking the next request.
// Option : SELECT_DRIVER_TIMEOUT_EN builds a WAIT-state timeout counter that
//          raises the sticky timeout flag (and err) after TIMEOUT_CYCLES.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module select_driver #(
  parameter int SYNC_STAGES    = 2,   // 2..4 flops per returned branch
  parameter int SETUP_CYCLES   = 1,   // edges sel_o is held before in_o toggles
  parameter int TIMEOUT_CYCLES = 255  // WAIT cycles before timeout is flagged
) (
  input  wire            clk,
  input  wire            rstn,
  select_driver_if.slave req,
  output logic           sel_o,
  output logic           in_o,
  input  wire            true_i,
  input  wire            false_i,
  output logic           err,
  output logic           timeout
);

  // Setup counter is loaded with SETUP_CYCLES-1 and counts down to zero.
  localparam int               c_scw        = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam logic [c_scw-1:0] c_setup_load = c_scw'(SETUP_CYCLES - 1);
  localparam logic [c_scw-1:0] c_setup_one  = c_scw'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [c_scw-1:0]       r_cnt;
  logic [c_scw-1:0]       w_cnt_nxt;
  logic                   w_sel_nxt;
  logic                   w_in_nxt;
  logic                   w_done_nxt;

  logic                   r_done;
  logic                   r_done_branch;
  logic                   r_err;

  logic                   r_ph_t;
  logic                   r_ph_f;
  logic [SYNC_STAGES-1:0] r_sync_t;
  logic [SYNC_STAGES-1:0] r_sync_f;

  logic                   w_ts;
  logic                   w_fs;
  logic                   w_t_ev;
  logic                   w_f_ev;
  logic                   w_in_wait;
  logic                   w_sel_ev;
  logic                   w_bad_ev;
  logic                   w_to_hit;

  //----------------------------------------------------------------------------
  // Branch observation
  //----------------------------------------------------------------------------

  // Bring the asynchronous select outputs into the clock domain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync_t <= '0;
      r_sync_f <= '0;
    end else begin
      r_sync_t <= {r_sync_t[SYNC_STAGES-2:0], true_i};
      r_sync_f <= {r_sync_f[SYNC_STAGES-2:0], false_i};
    end
  end

  assign w_ts = r_sync_t[SYNC_STAGES-1];
  assign w_fs = r_sync_f[SYNC_STAGES-1];

  // A 2-phase event is any difference between the synchronised level and the
  // phase last consumed on that branch.
  assign w_t_ev    = w_ts ^ r_ph_t;
  assign w_f_ev    = w_fs ^ r_ph_f;
  assign w_in_wait = (r_state == ST_WAIT);

  // Only the branch we steered to may complete a request, and only in WAIT.
  assign w_sel_ev  = w_in_wait & (sel_o ? w_t_ev : w_f_ev);

  // Any other transition is a protocol violation by the select element.
  assign w_bad_ev  = (w_t_ev & ~(w_in_wait &  sel_o)) |
                     (w_f_ev & ~(w_in_wait & ~sel_o));

  // Phase trackers consume every event, legal or not, so each transition is
  // reported exactly once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ph_t <= 1'b0;
      r_ph_f <= 1'b0;
    end else begin
      r_ph_t <= w_ts;
      r_ph_f <= w_fs;
    end
  end

  //----------------------------------------------------------------------------
  // Request FSM
  //----------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = sel_o;
    w_in_nxt    = in_o;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req.req_valid) begin
          w_sel_nxt   = req.req_sel;
          w_cnt_nxt   = c_setup_load;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_cnt == '0) begin
          w_in_nxt    = ~in_o;
          w_state_nxt = ST_WAIT;
        end else begin
          w_cnt_nxt   = r_cnt - c_setup_one;
        end
      end
      ST_WAIT: begin
        if (w_sel_ev) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered outputs, setup counter and sticky error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt         <= '0;
      sel_o         <= 1'b0;
      in_o          <= 1'b0;
      r_done        <= 1'b0;
      r_done_branch <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      sel_o  <= w_sel_nxt;
      in_o   <= w_in_nxt;
      r_done <= w_done_nxt;
      if (w_done_nxt) begin
        r_done_branch <= sel_o;
      end
      r_err  <= r_err | w_bad_ev | w_to_hit;
    end
  end

  //----------------------------------------------------------------------------
  // Optional WAIT timeout
  //----------------------------------------------------------------------------
`ifdef SELECT_DRIVER_TIMEOUT_EN
  localparam int               c_tcw  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_tcw-1:0] c_tlim = c_tcw'(TIMEOUT_CYCLES);
  localparam logic [c_tcw-1:0] c_tone = c_tcw'(1);

  logic [c_tcw-1:0] r_wcnt;
  logic [c_tcw-1:0] w_wcnt_inc;
  logic             w_wait_entry;
  logic             r_timeout;

  // Saturating increment so a very long stall cannot wrap the count.
  always_comb begin
    w_wcnt_inc = r_wcnt;
    if (r_wcnt != '1) begin
      w_wcnt_inc = r_wcnt + c_tone;
    end
  end

  assign w_wait_entry = (r_state == ST_SETUP) && (w_state_nxt == ST_WAIT);
  assign w_to_hit     = w_in_wait && !w_sel_ev && (w_wcnt_inc >= c_tlim);

  // Count WAIT cycles since entry and latch the timeout flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_wait_entry) begin
        r_wcnt <= '0;
      end else if (w_in_wait) begin
        r_wcnt <= w_wcnt_inc;
      end
      if (w_to_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  assign w_to_hit = 1'b0;
  // Constant low; TIMEOUT_CYCLES has no effect without the wait counter.
  assign timeout  = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  //----------------------------------------------------------------------------
  // Handshake outputs
  //----------------------------------------------------------------------------
  assign req.req_ready   = (r_state == ST_IDLE);
  assign req.done        = r_done;
  assign req.done_branch = r_done_branch;
  assign err             = r_err;

  //----------------------------------------------------------------------------
  // Protocol properties
  //----------------------------------------------------------------------------

  // Bundled data: the steering value only moves on an acceptance edge.
  a_sel_stable: assert property (@(posedge clk) disable iff (!rstn)
    (r_state != ST_IDLE) |=> $stable(sel_o));

  // The event output only moves when leaving SETUP.
  a_in_single: assert property (@(posedge clk) disable iff (!rstn)
    (r_state != ST_SETUP) |=> $stable(in_o));

  // Completion is a single-cycle pulse.
  a_done_pulse: assert property (@(posedge clk) disable iff (!rstn)
    r_done |=> !r_done);

endmodule
`default_nettype wire

// File: tb/tb_select_driver.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_select_driver
// Brief  : Self-checking bench for select_driver. Two instances are driven:
//          A with default parameters and B with SYNC_STAGES=3, SETUP_CYCLES=3,
//          TIMEOUT_CYCLES=10. Each has an ideal 2-phase select model that
//          answers an in_o transition with a transition on the steered branch.
//          Expectations come from the request rules: in_o moves SETUP_CYCLES
//          edges after acceptance, done follows SYNC_STAGES+1 edges after the
//          branch transition, and branches complete in request order.
// Option : SELECT_DRIVER_TIMEOUT_EN selects the timeout expectations.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module tb_select_driver;
  localparam int A_SYNC  = 2;
  localparam int A_SETUP = 1;
  localparam int B_SYNC  = 3;
  localparam int B_SETUP = 3;
  localparam int B_TO    = 10;
`ifdef SELECT_DRIVER_TIMEOUT_EN
  localparam logic EXP_TO = 1'b1;
`else
  localparam logic EXP_TO = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  select_driver_if a_if ();
  select_driver_if b_if ();

  logic a_sel, a_in, a_err, a_to;
  logic b_sel, b_in, b_err, b_to;
  wire  a_true, a_false, b_true, b_false;

  // Select model state (m*) plus bench-injected extra transitions (i*/j*).
  logic a_mt = 1'b0, a_mf = 1'b0, a_it = 1'b0, a_jf = 1'b0, a_mute = 1'b0;
  logic b_mt = 1'b0, b_mf = 1'b0, b_it = 1'b0, b_jf = 1'b0, b_mute = 1'b0;

  assign a_true  = a_mt ^ a_it;
  assign a_false = a_mf ^ a_jf;
  assign b_true  = b_mt ^ b_it;
  assign b_false = b_mf ^ b_jf;

  select_driver dut_a (
    .clk     (clk),
    .rstn    (rstn),
    .req     (a_if),
    .sel_o   (a_sel),
    .in_o    (a_in),
    .true_i  (a_true),
    .false_i (a_false),
    .err     (a_err),
    .timeout (a_to)
  );

  select_driver #(
    .SYNC_STAGES    (B_SYNC),
    .SETUP_CYCLES   (B_SETUP),
    .TIMEOUT_CYCLES (B_TO)
  ) dut_b (
    .clk     (clk),
    .rstn    (rstn),
    .req     (b_if),
    .sel_o   (b_sel),
    .in_o    (b_in),
    .true_i  (b_true),
    .false_i (b_false),
    .err     (b_err),
    .timeout (b_to)
  );

  // Ideal select A: 3 time units after an in transition, toggle the steered branch.
  always @(a_in or negedge rstn) begin
    if (rstn !== 1'b1) begin
      a_mt = 1'b0;
      a_mf = 1'b0;
    end else if (!a_mute) begin
      #3;
      if (a_sel) a_mt = ~a_mt;
      else       a_mf = ~a_mf;
    end
  end

  // Ideal select B, same behaviour.
  always @(b_in or negedge rstn) begin
    if (rstn !== 1'b1) begin
      b_mt = 1'b0;
      b_mf = 1'b0;
    end else if (!b_mute) begin
      #3;
      if (b_sel) b_mt = ~b_mt;
      else       b_mf = ~b_mf;
    end
  end

  function automatic logic g_in(bit b);   return b ? b_in : a_in;                     endfunction
  function automatic logic g_sel(bit b);  return b ? b_sel : a_sel;                   endfunction
  function automatic logic g_done(bit b); return b ? b_if.done : a_if.done;           endfunction
  function automatic logic g_br(bit b);   return b ? b_if.done_branch : a_if.done_branch; endfunction
  function automatic logic g_rdy(bit b);  return b ? b_if.req_ready : a_if.req_ready; endfunction
  function automatic logic g_err(bit b);  return b ? b_err : a_err;                   endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit b, input logic v, input logic s);
    if (b) begin
      b_if.req_valid = v;
      b_if.req_sel   = s;
    end else begin
      a_if.req_valid = v;
      a_if.req_sel   = s;
    end
  endtask

  // Present one request and follow it to done (bounded by maxc edges).
  // Edge numbers are counted from the acceptance edge (= 0).
  task automatic req_txn(input bit b, input logic s, input bit hold, input int maxc,
                         output int t_in, output int t_done, output int n_tog,
                         output bit sel_ok, output bit rdy_ok, output logic br);
    logic prev_in;
    t_in = -1; t_done = -1; n_tog = 0; sel_ok = 1'b1; rdy_ok = 1'b1; br = 1'bx;
    prev_in = g_in(b);
    set_req(b, 1'b1, s);
    tick();
    if (!hold) set_req(b, 1'b0, s);
    for (int k = 0; k <= maxc; k++) begin
      if (k > 0) tick();
      if (g_sel(b) !== s) sel_ok = 1'b0;
      if (g_in(b) !== prev_in) begin
        n_tog++;
        if (t_in < 0) t_in = k;
        prev_in = g_in(b);
      end
      if (g_done(b) === 1'b1) begin
        t_done = k;
        br     = g_br(b);
        if (g_rdy(b) !== 1'b1) rdy_ok = 1'b0;
        break;
      end
      if (g_rdy(b) !== 1'b0) rdy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    set_req(1'b0, 1'b0, 1'b0);
    set_req(1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    total++;
    if ({a_sel, a_in, a_if.done, a_if.done_branch, a_err, a_to, a_if.req_ready} !== 7'b0000001) begin
      bad++;
      $display("FAIL reset_a: got %b want 0000001", {a_sel, a_in, a_if.done, a_if.done_branch, a_err, a_to, a_if.req_ready});
    end
    total++;
    if ({b_sel, b_in, b_if.done, b_if.done_branch, b_err, b_to, b_if.req_ready} !== 7'b0000001) begin
      bad++;
      $display("FAIL reset_b: got %b want 0000001", {b_sel, b_in, b_if.done, b_if.done_branch, b_err, b_to, b_if.req_ready});
    end
    rstn = 1'b1;
    tick();
    total++;
    if ({a_if.req_ready, a_if.done, b_if.req_ready, b_if.done} !== 4'b1010) begin
      bad++;
      $display("FAIL release_idle: got %b want 1010", {a_if.req_ready, a_if.done, b_if.req_ready, b_if.done});
    end
  endtask

  task automatic test_single();
    int t_in, t_done, n_tog;
    bit sel_ok, rdy_ok;
    logic br;
    req_txn(1'b0, 1'b1, 1'b0, 20, t_in, t_done, n_tog, sel_ok, rdy_ok, br);
    total++;
    if (t_in !== A_SETUP) begin
      bad++; $display("FAIL single_in_edge: got %0d want %0d", t_in, A_SETUP);
    end
    total++;
    if (t_done !== A_SETUP + A_SYNC + 1) begin
      bad++; $display("FAIL single_done_edge: got %0d want %0d", t_done, A_SETUP + A_SYNC + 1);
    end
    total++;
    if (br !== 1'b1) begin
      bad++; $display("FAIL single_branch: got %b want 1", br);
    end
    total++;
    if ({n_tog == 1, sel_ok, rdy_ok, a_err} !== 4'b1110) begin
      bad++; $display("FAIL single_flags: got tog=%0d sel_ok=%0d rdy_ok=%0d err=%b want 1 1 1 0", n_tog, sel_ok, rdy_ok, a_err);
    end
    tick();
    total++;
    if (a_if.done !== 1'b0) begin
      bad++; $display("FAIL single_done_pulse: got %b want 0", a_if.done);
    end
  endtask

  task automatic test_back_to_back();
    logic seq [4];
    int   t_in, t_done, n_tog, tog_sum;
    bit   sel_ok, rdy_ok;
    logic br;
    seq = '{1'b1, 1'b0, 1'b0, 1'b1};
    tog_sum = 0;
    for (int i = 0; i < 4; i++) begin
      req_txn(1'b0, seq[i], 1'b1, 20, t_in, t_done, n_tog, sel_ok, rdy_ok, br);
      tog_sum += n_tog;
      total++;
      if (br !== seq[i]) begin
        bad++; $display("FAIL b2b_branch[%0d]: got %b want %b", i, br, seq[i]);
      end
      total++;
      if (t_in !== A_SETUP || t_done !== A_SETUP + A_SYNC + 1) begin
        bad++; $display("FAIL b2b_timing[%0d]: got in=%0d done=%0d want in=%0d done=%0d", i, t_in, t_done, A_SETUP, A_SETUP + A_SYNC + 1);
      end
      total++;
      if ({sel_ok, rdy_ok} !== 2'b11) begin
        bad++; $display("FAIL b2b_stable_ready[%0d]: got sel_ok=%0d rdy_ok=%0d want 1 1", i, sel_ok, rdy_ok);
      end
    end
    set_req(1'b0, 1'b0, 1'b0);
    tick();
    total++;
    if (tog_sum !== 4 || a_err !== 1'b0) begin
      bad++; $display("FAIL b2b_toggles: got tog=%0d err=%b want 4 0", tog_sum, a_err);
    end
  endtask

  task automatic test_random();
    logic exp_q [$];
    logic s, e;
    bit   b, sel_ok, rdy_ok;
    int   gap, t_in, t_done, n_tog, e_in, e_done;
    logic br;
    for (int i = 0; i < 10; i++) begin
      b   = 1'($urandom_range(0, 1));
      s   = 1'($urandom_range(0, 1));
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        tick();
        total++;
        if (g_done(b) !== 1'b0 || g_rdy(b) !== 1'b1) begin
          bad++; $display("FAIL rand_idle[%0d]: got done=%b ready=%b want 0 1", i, g_done(b), g_rdy(b));
        end
      end
      exp_q.push_back(s);
      e_in   = b ? B_SETUP : A_SETUP;
      e_done = e_in + (b ? B_SYNC : A_SYNC) + 1;
      req_txn(b, s, 1'b0, 30, t_in, t_done, n_tog, sel_ok, rdy_ok, br);
      e = exp_q.pop_front();
      total++;
      if (br !== e || t_done !== e_done || t_in !== e_in) begin
        bad++; $display("FAIL rand_txn[%0d] dut=%0d: got br=%b in=%0d done=%0d want br=%b in=%0d done=%0d", i, b, br, t_in, t_done, e, e_in, e_done);
      end
    end
    total++;
    if (a_err !== 1'b0 || b_err !== 1'b0) begin
      bad++; $display("FAIL rand_err: got a=%b b=%b want 0 0", a_err, b_err);
    end
  endtask

  task automatic test_setup_cycles();
    int   t_in, t_done, n_tog;
    bit   sel_ok, rdy_ok;
    logic br;
    for (int i = 0; i < 2; i++) begin
      req_txn(1'b1, logic'(i == 0), 1'b0, 30, t_in, t_done, n_tog, sel_ok, rdy_ok, br);
      total++;
      if (t_in !== B_SETUP || n_tog !== 1) begin
        bad++; $display("FAIL setup3_in[%0d]: got edge=%0d toggles=%0d want %0d 1", i, t_in, n_tog, B_SETUP);
      end
      total++;
      if (t_done !== B_SETUP + B_SYNC + 1 || br !== logic'(i == 0)) begin
        bad++; $display("FAIL setup3_done[%0d]: got edge=%0d br=%b want %0d %b", i, t_done, br, B_SETUP + B_SYNC + 1, logic'(i == 0));
      end
      total++;
      if ({sel_ok, rdy_ok} !== 2'b11) begin
        bad++; $display("FAIL setup3_stable[%0d]: got sel_ok=%0d rdy_ok=%0d want 1 1", i, sel_ok, rdy_ok);
      end
    end
  endtask

  task automatic test_wrong_branch();
    bit   seen;
    logic d_early;
    a_mute = 1'b1;
    set_req(1'b0, 1'b1, 1'b1);
    tick();
    set_req(1'b0, 1'b0, 1'b0);
    tick();
    a_jf = ~a_jf;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (a_if.done !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL wrong_no_done: got done seen=%0d want 0", seen);
    end
    total++;
    if (a_err !== 1'b1 || a_if.req_ready !== 1'b0) begin
      bad++; $display("FAIL wrong_err: got err=%b ready=%b want 1 0", a_err, a_if.req_ready);
    end
    a_it = ~a_it;
    tick();
    tick();
    d_early = a_if.done;
    tick();
    total++;
    if ({d_early, a_if.done, a_if.done_branch} !== 3'b011) begin
      bad++; $display("FAIL wrong_late_done: got %b want 011", {d_early, a_if.done, a_if.done_branch});
    end
    tick();
    total++;
    if (a_err !== 1'b1 || a_if.req_ready !== 1'b1) begin
      bad++; $display("FAIL wrong_sticky: got err=%b ready=%b want 1 1", a_err, a_if.req_ready);
    end
    a_mute = 1'b0;
  endtask

  task automatic test_reset_mid();
    int   t_in, t_done, n_tog;
    bit   sel_ok, rdy_ok;
    logic br;
    a_mute = 1'b1;
    set_req(1'b0, 1'b1, 1'b1);
    tick();
    set_req(1'b0, 1'b0, 1'b0);
    tick();
    #2;
    rstn = 1'b0;
    a_it = 1'b0;
    a_jf = 1'b0;
    #1;
    total++;
    if ({a_sel, a_in, a_if.done, a_if.done_branch, a_err, a_to, a_if.req_ready} !== 7'b0000001) begin
      bad++; $display("FAIL async_reset: got %b want 0000001", {a_sel, a_in, a_if.done, a_if.done_branch, a_err, a_to, a_if.req_ready});
    end
    tick();
    tick();
    total++;
    if (a_if.done !== 1'b0 || a_in !== 1'b0) begin
      bad++; $display("FAIL reset_hold: got done=%b in=%b want 0 0", a_if.done, a_in);
    end
    rstn = 1'b1;
    a_mute = 1'b0;
    req_txn(1'b0, 1'b0, 1'b0, 20, t_in, t_done, n_tog, sel_ok, rdy_ok, br);
    total++;
    if (t_done !== A_SETUP + A_SYNC + 1 || br !== 1'b0 || g_err(1'b0) !== 1'b0) begin
      bad++; $display("FAIL post_reset_req: got done=%0d br=%b err=%b want %0d 0 0", t_done, br, a_err, A_SETUP + A_SYNC + 1);
    end
  endtask

  task automatic test_timeout();
    bit   seen;
    total++;
    if (b_err !== 1'b0 || b_to !== 1'b0) begin
      bad++; $display("FAIL to_pre: got err=%b timeout=%b want 0 0", b_err, b_to);
    end
    b_mute = 1'b1;
    set_req(1'b1, 1'b1, 1'b1);
    tick();
    set_req(1'b1, 1'b0, 1'b0);
    repeat (B_SETUP) tick();
    repeat (B_TO - 1) tick();
    total++;
    if (b_to !== 1'b0) begin
      bad++; $display("FAIL to_early: got %b want 0", b_to);
    end
    tick();
    total++;
    if (b_to !== EXP_TO || b_err !== EXP_TO) begin
      bad++; $display("FAIL to_reach: got timeout=%b err=%b want %b %b", b_to, b_err, EXP_TO, EXP_TO);
    end
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (b_if.done !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || b_if.req_ready !== 1'b0) begin
      bad++; $display("FAIL to_stay_wait: got done seen=%0d ready=%b want 0 0", seen, b_if.req_ready);
    end
    b_it = ~b_it;
    seen = 1'b0;
    repeat (B_SYNC) begin
      tick();
      if (b_if.done !== 1'b0) seen = 1'b1;
    end
    tick();
    total++;
    if ({seen, b_if.done, b_if.done_branch} !== 3'b011) begin
      bad++; $display("FAIL to_late_done: got %b want 011", {seen, b_if.done, b_if.done_branch});
    end
    total++;
    if (b_to !== EXP_TO) begin
      bad++; $display("FAIL to_sticky: got %b want %b", b_to, EXP_TO);
    end
    b_mute = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion want summary before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_setup_cycles();
    test_wrong_branch();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/select_driver.md
Name: select_driver

Overview:
- Clocked front-end that feeds a 2-phase select element from a synchronous valid/ready stream of 1-bit steering decisions.
- Per accepted request:
  - drives the select's steering input (bundled data);
  - issues one 2-phase event (a transition) on the select's event input;
  - watches the select's true/false outputs through synchronisers;
  - reports completion before accepting the next request.
- Sits directly upstream of the select element and shares its active-low reset.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on each returned branch output; legal range 2..4.
- SETUP_CYCLES, 1, clock edges that sel_o is held stable before in_o toggles; legal minimum 1.
- TIMEOUT_CYCLES, 255, WAIT-state cycles before a timeout is flagged; used only when the optional feature is enabled.

Ports:
- clk  input  1  single clock.
- rstn  input  1  asynchronous, active-low reset; the same net also resets the select element.
- req_valid  input  1  request present.
- req_sel  input  1  branch to steer to (1 = true, 0 = false).
- req_ready  output  1  block can accept a request.
- sel_o  output  1  to select sel; bundled-data steering value.
- in_o  output  1  to select in; 2-phase event, one toggle per request.
- true_i  input  1  from select true; asynchronous, synchronised internally.
- false_i  input  1  from select false; asynchronous, synchronised internally.
- done  output  1  one-cycle pulse on completion.
- done_branch  output  1  branch completed, valid while done = 1.
- err  output  1  sticky protocol error.
- timeout  output  1  sticky timeout flag; tied 0 when the feature is disabled.

Behaviour:
- Reset (rstn low, asynchronous) sets:
  - sel_o = 0, in_o = 0, done = 0, done_branch = 0, err = 0, timeout = 0;
  - FSM = IDLE;
  - phase trackers ph_t = 0 and ph_f = 0, matching the select's reset state;
  - all synchroniser flops = 0.
- req_ready = 1 only in IDLE. It is combinational from state.
- FSM IDLE:
  - on req_valid & req_ready at an edge: sel_o <= req_sel, setup counter <= SETUP_CYCLES - 1, go to SETUP.
- FSM SETUP:
  - counter decrements each edge;
  - at the edge where the counter is 0: in_o <= ~in_o, go to WAIT;
  - result: in_o toggles exactly SETUP_CYCLES edges after the acceptance edge.
- FSM WAIT:
  - let ts and fs be the synchronised true_i and false_i;
  - selected branch event (sel_o = 1 and ts != ph_t, or sel_o = 0 and fs != ph_f):
    - flip that tracker;
    - done <= 1 for one cycle, done_branch <= sel_o;
    - go to IDLE; req_ready is 1 in the cycle after the done edge.
  - unselected branch event: flip that tracker, set err; the FSM does not leave WAIT because of it.
- Any branch event in IDLE or SETUP: flip the tracker, set err.
- err is cleared only by reset.
- sel_o is held constant from the acceptance edge through the done edge. This is the bundled-data constraint.
- in_o never toggles more than once per request.
- Latency:
  - branch transition → done high = SYNC_STAGES + 1 edges, counted from the first synchroniser capture edge;
  - minimum request-to-request period = SETUP_CYCLES + SYNC_STAGES + 2 cycles plus the external select delay.
- Simultaneous events in one cycle:
  - both branches toggle in WAIT: the selected branch completes (done) and the other sets err;
  - an error and done in the same cycle are both reported.
- rstn asserted mid-request: the FSM returns immediately to IDLE with in_o = 0. No done is issued for the aborted request.
- Requests presented while req_ready = 0 are ignored; they are held upstream.

Optional Feature:
- Macro: SELECT_DRIVER_TIMEOUT_EN.
- Enabled:
  - a wait counter clears on entry to WAIT and increments each WAIT cycle, saturating;
  - when the count reaches TIMEOUT_CYCLES with no selected-branch event, timeout and err are set (sticky);
  - the FSM stays in WAIT, and a late event still completes the request normally with done.
- Disabled: no counter is built; timeout is constant 0.

Test Plan:
- Reset, then req_sel = 1 with an ideal select model (delay 3 ns):
  - sel_o = 1, in_o toggles 1 edge after acceptance;
  - true_i toggles; done = 1, done_branch = 1 exactly 3 edges later (defaults);
  - err = 0.
- Back-to-back requests 1, 0, 0, 1 with req_valid held high:
  - in_o toggles 4 times;
  - done_branch sequence is 1, 0, 0, 1;
  - sel_o never changes between acceptance and done;
  - req_ready low throughout SETUP and WAIT.
- Select model toggles false_i while sel_o = 1 in WAIT:
  - err = 1 and sticky;
  - no done until true_i toggles;
  - err stays 1 until rstn pulses low.
- SETUP_CYCLES = 3: in_o toggles exactly 3 edges after acceptance; sel_o stable during those edges.
- Pulse rstn low while in WAIT:
  - all outputs return to reset values asynchronously, with no clock edge needed;
  - the next request after release completes normally.
- With SELECT_DRIVER_TIMEOUT_EN and TIMEOUT_CYCLES = 10, select model silent:
  - timeout = 1 and err = 1 after 10 WAIT cycles;
  - a later true_i toggle still produces done.
- Without SELECT_DRIVER_TIMEOUT_EN, same stimulus: timeout stays 0.
